// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame engine.
//   - FSM state encoding (exposed on the debug state port)
//   - error codes returned in the low byte of the error word
//   - byte-lane index width and dataa field positions
package uart_frame_pkg;

  // state              | meaning
  // IDLE               | waiting for start
  // SEND_BYTE          | waiting for tx idle, then strobes the next frame byte
  // WAIT_TX            | one guard cycle, then waits for tx to finish
  // WAIT_DATA          | collecting RX_LEN response data bytes
  // WAIT_CHECKSUM      | collecting the response checksum byte
  // VERIFY_CHECKSUM    | compares computed and received checksum
  // RETRY              | clears RX state and restarts the frame
  // DONE               | one-cycle completion with done/err
  typedef enum logic [4:0] {
    ST_IDLE            = 5'd0,
    ST_SEND_BYTE       = 5'd1,
    ST_WAIT_TX         = 5'd2,
    ST_WAIT_DATA       = 5'd3,
    ST_WAIT_CHECKSUM   = 5'd4,
    ST_VERIFY_CHECKSUM = 5'd5,
    ST_RETRY           = 5'd6,
    ST_DONE            = 5'd7
  } state_t;

  localparam logic [7:0] ERR_CHK     = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h02;
  localparam logic [7:0] ERR_LEN     = 8'h03;

  // Wide enough for frame byte index 0..7+1 (cmd, up to 7 payload, checksum).
  localparam int LANE_W = 4;

  localparam int CMD_LSB    = 0;
  localparam int TX_LEN_LSB = 8;
  localparam int RX_LEN_LSB = 12;
  localparam int LEN_W      = 3;

endpackage

// File: rtl/uart_frame_engine_checksum.sv
// Running 8-bit frame checksum.
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart the checksum at zero (has priority over add)
//   add        : fold byte_in into the checksum this cycle
//   byte_in    : byte to fold in
//   sum        : current checksum (CHK_MODE 0 = sum mod 256, 1 = XOR)
module frame_checksum #(
  parameter int CHK_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum <= 8'h00;
    end else if (add) begin
      if (CHK_MODE == 1) sum <= sum ^ byte_in;
      else               sum <= sum + byte_in;
    end
  end

endmodule

// File: rtl/uart_frame_engine.sv
// Custom-instruction UART frame engine: sends cmd + payload + checksum to the
// UART transmitter, collects a checksummed response, retries on error.
//   clk, reset       : clock, synchronous active-high reset
//   start            : request (accepted in IDLE only)
//   dataa            : [7:0] cmd, [10:8] TX_LEN, [14:12] RX_LEN
//   datab            : TX payload, LSB byte first
//   result/done/err  : response word or error word, completion pulse, failure flag
//   txdata/wr_en     : byte and write strobe to UART tx; tx_busy from UART tx
//   rxdata/rdy       : byte and valid from UART rx; rdy_clr acknowledges it
//   state            : current FSM state (debug)
module uart_frame_engine #(
  parameter int DATA_W         = 32,
  parameter int MAX_PAYLOAD    = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 2,
  parameter int CHK_MODE       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              err,
  output logic [7:0]        txdata,
  output logic              wr_en,
  input  logic              tx_busy,
  input  logic [7:0]        rxdata,
  input  logic              rdy,
  output logic              rdy_clr,
  output logic [4:0]        state
);
  import uart_frame_pkg::*;

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [LANE_W-1:0]  MAX_LEN    = LANE_W'(MAX_PAYLOAD);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  state_t              state_q;
  logic [7:0]          cmd_q;
  logic [LANE_W-1:0]   tx_len_q, rx_len_q;
  logic [DATA_W-1:0]   payload_q, shreg;
  logic [LANE_W-1:0]   byte_idx, rx_cnt;
  logic [TIMER_W-1:0]  timer;
  logic [RETRY_W-1:0]  retry_cnt;
  logic                guard, skip, chk_sent;
  logic [DATA_W-1:0]   rx_data;
  logic [7:0]          rx_chk;

  logic                tx_fire, tx_add, rx_fire, rx_add, frame_clr;
  logic [7:0]          tx_byte, tx_sum, rx_sum;
  logic [LANE_W-1:0]   tx_last, in_tx_len, in_rx_len;

  assign state = state_q;

  always_comb begin
    in_tx_len = LANE_W'(dataa[TX_LEN_LSB +: LEN_W]);
    in_rx_len = LANE_W'(dataa[RX_LEN_LSB +: LEN_W]);
    // Index of the checksum byte within the frame.
    tx_last   = tx_len_q + LANE_W'(1);
    tx_fire   = (state_q == ST_SEND_BYTE) && !tx_busy;
    tx_add    = tx_fire && (byte_idx != tx_last);
    tx_byte   = (byte_idx == '0) ? cmd_q : shreg[7:0];
    // skip masks the cycle after rdy_clr, when rdy may still show the old byte.
    rx_fire   = ((state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_CHECKSUM)) && rdy && !skip;
    rx_add    = rx_fire && (state_q == ST_WAIT_DATA);
    frame_clr = ((state_q == ST_IDLE) && start) || (state_q == ST_RETRY);
  end

  frame_checksum #(.CHK_MODE(CHK_MODE)) u_tx_chk (
    .clk(clk), .reset(reset), .clr(frame_clr), .add(tx_add), .byte_in(tx_byte), .sum(tx_sum)
  );

  frame_checksum #(.CHK_MODE(CHK_MODE)) u_rx_chk (
    .clk(clk), .reset(reset), .clr(frame_clr), .add(rx_add), .byte_in(rxdata), .sum(rx_sum)
  );

  function automatic logic [DATA_W-1:0] err_word(input logic [7:0] code);
    err_word = {{(DATA_W-8){1'b1}}, code};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      tx_len_q  <= '0;
      rx_len_q  <= '0;
      payload_q <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      rx_cnt    <= '0;
      timer     <= '0;
      retry_cnt <= '0;
      guard     <= 1'b0;
      skip      <= 1'b0;
      chk_sent  <= 1'b0;
      rx_data   <= '0;
      rx_chk    <= '0;
      result    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      txdata    <= '0;
      wr_en     <= 1'b0;
      rdy_clr   <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      rdy_clr <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      skip    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cmd_q     <= dataa[CMD_LSB +: 8];
            tx_len_q  <= in_tx_len;
            rx_len_q  <= in_rx_len;
            payload_q <= datab;
            shreg     <= datab;
            byte_idx  <= '0;
            rx_cnt    <= '0;
            retry_cnt <= '0;
            chk_sent  <= 1'b0;
            rx_data   <= '0;
            if ((in_tx_len > MAX_LEN) || (in_rx_len > MAX_LEN)) begin
              result  <= err_word(ERR_LEN);
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SEND_BYTE;
            end
          end
        end

        ST_SEND_BYTE: begin
          if (!tx_busy) begin
            wr_en    <= 1'b1;
            guard    <= 1'b1;
            byte_idx <= byte_idx + LANE_W'(1);
            state_q  <= ST_WAIT_TX;
            if (byte_idx == tx_last) begin
              txdata   <= tx_sum;
              chk_sent <= 1'b1;
            end else begin
              txdata <= tx_byte;
              if (byte_idx != '0) shreg <= shreg >> 8;
            end
          end
        end

        ST_WAIT_TX: begin
          // The UART raises tx_busy a cycle after wr_en, so the first cycle is ignored.
          if (guard) begin
            guard <= 1'b0;
          end else if (!tx_busy) begin
            if (!chk_sent) begin
              state_q <= ST_SEND_BYTE;
            end else begin
              timer   <= TIMER_LOAD;
              rx_cnt  <= '0;
              state_q <= (rx_len_q != '0) ? ST_WAIT_DATA : ST_WAIT_CHECKSUM;
            end
          end
        end

        ST_WAIT_DATA, ST_WAIT_CHECKSUM: begin
          if (rx_fire) begin
            rdy_clr <= 1'b1;
            skip    <= 1'b1;
            timer   <= TIMER_LOAD;
            if (state_q == ST_WAIT_DATA) begin
              for (int i = 0; i < MAX_PAYLOAD; i++) begin
                if (rx_cnt == LANE_W'(i)) rx_data[8*i +: 8] <= rxdata;
              end
              rx_cnt <= rx_cnt + LANE_W'(1);
              if (rx_cnt + LANE_W'(1) == rx_len_q) state_q <= ST_WAIT_CHECKSUM;
            end else begin
              rx_chk  <= rxdata;
              state_q <= ST_VERIFY_CHECKSUM;
            end
          end else if (timer == '0) begin
            if (retry_cnt < RETRY_MAX) begin
              state_q <= ST_RETRY;
            end else begin
              result  <= err_word(ERR_TIMEOUT);
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        ST_VERIFY_CHECKSUM: begin
          if (rx_chk == rx_sum) begin
            result  <= rx_data;
            done    <= 1'b1;
            state_q <= ST_DONE;
          end else if (retry_cnt < RETRY_MAX) begin
            state_q <= ST_RETRY;
          end else begin
            result  <= err_word(ERR_CHK);
            err     <= 1'b1;
            done    <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_RETRY: begin
          retry_cnt <= retry_cnt + RETRY_W'(1);
          rx_data   <= '0;
          rx_cnt    <= '0;
          timer     <= TIMER_LOAD;
          byte_idx  <= '0;
          shreg     <= payload_q;
          chk_sent  <= 1'b0;
          state_q   <= ST_SEND_BYTE;
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_frame_engine.md
Name: uart_frame_engine

Overview:
- Parametrised successor to the single-command custom-instruction UART state machine.
- Accepts a start pulse with command and payload, serialises a checksummed frame to the UART transmitter, then collects a variable-length response.
- Verifies the response checksum, retries on checksum error or timeout, and returns packed data on result with a done pulse.
- Sits between the processor custom-instruction port and the UART rx/tx cores.

Parameters:
- DATA_W, 32, width of dataa/datab/result.
- MAX_PAYLOAD, 4, maximum TX or RX payload bytes; must be ≤ DATA_W/8.
- TIMEOUT_CYCLES, 50000, clocks allowed between received bytes before timeout.
- MAX_RETRY, 2, retries after the first attempt.
- CHK_MODE, 0, checksum type: 0 = 8-bit sum mod 256, 1 = XOR.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request; ignored unless state is IDLE
- dataa  in  DATA_W  [7:0] cmd, [10:8] TX_LEN, [14:12] RX_LEN
- datab  in  DATA_W  TX payload, sent LSB byte first
- result  out  DATA_W  response data or error word
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = failure
- txdata  out  8  byte to UART tx
- wr_en  out  1  one-cycle tx write strobe
- tx_busy  in  1  UART tx busy
- rxdata  in  8  UART rx byte
- rdy  in  1  rx byte valid
- rdy_clr  out  1  one-cycle rx acknowledge
- state  out  5  current FSM state (debug)

Behaviour:
- Reset, applied at any time including mid-frame:
  - state = IDLE, all outputs 0, counters and checksum cleared.
  - result is cleared to 0; otherwise it holds its value until the next accepted start.
- State encoding: IDLE=0, SEND_BYTE=1, WAIT_TX=2, WAIT_DATA=3, WAIT_CHECKSUM=4, VERIFY_CHECKSUM=5, RETRY=6, DONE=7.
- Start acceptance: IDLE with start=1 latches dataa and datab.
  - If TX_LEN or RX_LEN > MAX_PAYLOAD: go to DONE, result = {DATA_W-8 ones, 8'h03}, err = 1. Nothing is transmitted.
- TX frame order: cmd, then TX_LEN payload bytes, then checksum over cmd and payload.
- SEND_BYTE:
  - When tx_busy = 0, drive txdata and pulse wr_en for 1 cycle, then go to WAIT_TX.
  - While tx_busy = 1, wait without strobing.
- WAIT_TX:
  - 1-cycle guard in which tx_busy is ignored.
  - Then wait for tx_busy = 0.
  - Go to the next SEND_BYTE, or after the checksum byte, to WAIT_DATA (RX_LEN > 0) or WAIT_CHECKSUM (RX_LEN = 0).
- Receiving (WAIT_DATA / WAIT_CHECKSUM):
  - On rdy = 1, capture rxdata and pulse rdy_clr for 1 cycle.
  - rdy is not sampled in the cycle after rdy_clr.
  - WAIT_DATA packs data bytes LSB first into the result register; upper bytes are zero.
  - After RX_LEN bytes, go to WAIT_CHECKSUM.
  - WAIT_CHECKSUM captures 1 byte, then goes to VERIFY_CHECKSUM.
- Timeout counter:
  - Cleared on entry to WAIT_DATA and on every received byte.
  - Reaching TIMEOUT_CYCLES in WAIT_DATA or WAIT_CHECKSUM: error code 2.
- VERIFY_CHECKSUM (1 cycle): compares the computed RX checksum over the data bytes with the received byte.
  - Match: DONE, err = 0.
  - Mismatch: error code 1.
- Errors with codes 1 and 2:
  - If retries used < MAX_RETRY: RETRY (1 cycle; clears the RX checksum, packed data and timer; increments the retry count), then SEND_BYTE resends the full frame.
  - Otherwise: DONE with result = {ones, code}, err = 1.
- DONE: done = 1 for exactly 1 cycle, then IDLE.
- rdy arriving in IDLE, SEND_BYTE or WAIT_TX: not acknowledged; it is left pending.

Decomposition:
- Package uart_frame_pkg:
  - state localparams
  - error codes ERR_CHK=1, ERR_TIMEOUT=2, ERR_LEN=3
  - byte-lane index width
  - field bit positions for cmd, TX_LEN and RX_LEN
- Sub-module frame_checksum:
  - Inputs: clk, reset, clr, add, byte_in.
  - Output: 8-bit sum.
  - Parameter: CHK_MODE.
  - Two instances: one TX, one RX.

Test Plan:
- dataa = 0x0000_2061, TX_LEN = 0, RX_LEN = 2:
  - Expected TX bytes 0x61, 0x61.
  - Bench replies 0x12, 0x34, 0x46.
  - Expected: result = 0x0000_3412, done pulses once, err = 0, one rdy_clr pulse per byte.
- dataa = 0x0000_0261, datab = 0x0000_BEEF:
  - Expected TX bytes 0x61, 0xEF, 0xBE, 0x0E.
  - wr_en is never asserted while tx_busy = 1.
- Checksum retry, RX_LEN = 2:
  - Bench replies 0x12, 0x34, 0x00 on the first attempt.
  - Expected: the full frame is resent.
  - Bench replies correctly on the second attempt; expected result = 0x0000_3412, err = 0.
- Timeout exhaustion, TIMEOUT_CYCLES = 100, MAX_RETRY = 1, no rx:
  - Expected: 2 frames sent, then done with result = 0xFFFF_FF02, err = 1.
- Length error, dataa TX_LEN = 5:
  - Expected: no wr_en, result = 0xFFFF_FF03, done within 2 cycles.
- Reset mid-frame:
  - Assert reset in WAIT_CHECKSUM (state = 4).
  - Expected: next cycle state = 0, done = 0, wr_en = 0, rdy_clr = 0.
  - A new start then completes normally.
